// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate sweep sequencer: FSM state codes and the
// truth tables of the common 2-input gates (bit index is {a,b}).
package gate_sweep_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_DRIVE = ST_DRIVE,
    S_WAIT  = ST_WAIT,
    S_CHECK = ST_CHECK,
    S_DONE  = ST_DONE
  } state_e;

  localparam logic [3:0] TRUTH_NOR  = 4'b0001;
  localparam logic [3:0] TRUTH_NAND = 4'b0111;
  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [3:0] TRUTH_XOR  = 4'b0110;

endpackage

// File: rtl/gate_sweep_timer.sv
// Loadable 8-bit down-counter timing the settle window of each vector.
// `zero` flags the decrement that brings the count to 0.
module gate_sweep_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] value,
  output logic       zero
);

  logic [7:0] value_d;
  logic [7:0] value_q;

  // next count: load wins over decrement, and the count never wraps below 0
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (dec && (value_q != 8'd0)) begin
      value_d = value_q - 8'd1;
    end else begin
      value_d = value_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= 8'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = dec && (value_q <= 8'd1);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives a 2-input gate under test through 00,01,10,11 and checks y against TRUTH.
// Define GATE_SWEEP_ERR_COUNT_EN to add the saturating err_count port.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter logic [3:0] TRUTH      = TRUTH_NOR,
  parameter int         SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
`ifdef GATE_SWEEP_ERR_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC);

  state_e     state_d, state_q;
  logic [1:0] idx_d, idx_q;
  logic       a_d, a_q;
  logic       b_d, b_q;
  logic       busy_d, busy_q;
  logic       done_d, done_q;
  logic       pass_d, pass_q;
  logic [3:0] fail_mask_d, fail_mask_q;
  logic       mismatch;
  logic       tmr_load;
  logic       tmr_dec;
  logic [7:0] tmr_value;
  logic       tmr_zero;

  gate_sweep_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LD),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // sequencer next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    mismatch    = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fail_mask_d = 4'b0000;
          pass_d      = 1'b0;
          idx_d       = 2'd0;
          busy_d      = 1'b1;
          state_d     = S_DRIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        {a_d, b_d} = idx_q;
        tmr_load   = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        tmr_dec = 1'b1;
        // a zero count can only appear if the timer was disturbed; never stall on it
        if (tmr_zero || (tmr_value == 8'd0)) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CHECK: begin
        mismatch = (y != TRUTH[idx_q]);
        if (mismatch) begin
          fail_mask_d[idx_q] = 1'b1;
        end else begin
          fail_mask_d = fail_mask_q;
        end
        if (idx_q == 2'd3) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_mask_d == 4'b0000);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // sequencer and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;

`ifdef GATE_SWEEP_ERR_COUNT_EN
  logic [7:0] err_count_d, err_count_q;

  // lifetime mismatch count, saturating, cleared only by reset
  always_comb begin
    if (mismatch && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= 8'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule
